// File: rtl/cell_pool_pkg.sv
// Shared constants, FSM state encoding and address helper for the cell_pool allocator.
package cell_pool_pkg;

    localparam logic [15:0] UNDEF         = 16'h0000;
    localparam logic [11:0] NIL           = 12'd0;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h5000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_POP  = 1'b1
    } state_t;

    // Cell index (already zero-extended) placed inside the address window.
    function automatic logic [15:0] cell_addr(input logic [15:0] base, input logic [15:0] idx);
        return base | idx;
    endfunction

endpackage

// File: rtl/cell_pool_if.sv
// Request/response bundle between a requester (core/evaluator) and cell_pool.
interface cell_pool_if #(
    parameter int ADDR_SZ = 4,
    parameter int DATA_SZ = 16
);
    logic               i_alloc;
    logic [DATA_SZ-1:0] i_data;
    logic [15:0]        o_addr;
    logic               o_valid;
    logic               i_free;
    logic [15:0]        i_addr;
    logic               i_wr;
    logic               i_rd;
    logic [DATA_SZ-1:0] o_data;
    logic               o_ready;
    logic               o_full;
    logic [ADDR_SZ-1:0] o_used;
    logic               o_err;

    modport master (
        output i_alloc, i_data, i_free, i_addr, i_wr, i_rd,
        input  o_addr, o_valid, o_data, o_ready, o_full, o_used, o_err
    );

    modport slave (
        input  i_alloc, i_data, i_free, i_addr, i_wr, i_rd,
        output o_addr, o_valid, o_data, o_ready, o_full, o_used, o_err
    );
endinterface

// File: rtl/cell_ram.sv
// Single-port cell storage with write enable and an enabled, registered read (BRAM-inferable).
module cell_ram #(
    parameter int ADDR_SZ = 4,
    parameter int DATA_SZ = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [ADDR_SZ-1:0] addr,
    input  logic [DATA_SZ-1:0] wdata,
    output logic [DATA_SZ-1:0] rdata
);
    logic [DATA_SZ-1:0] mem [0:(2**ADDR_SZ)-1];

    // Write port and read register share the single address; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/cell_pool.sv
// Heap-cell allocator: fresh cells from a bump index, recycled cells via a LIFO list threaded through the RAM.
// Optional FREE_CHECK_EN adds an in-use bitmap that rejects free/rd/wr of cells not currently allocated.
module cell_pool
    import cell_pool_pkg::*;
#(
    parameter int          ADDR_SZ   = 4,
    parameter int          DATA_SZ   = 16,
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input logic        i_clk,
    input logic        i_rst,
    cell_pool_if.slave bus
);
    localparam logic [ADDR_SZ-1:0] NIL_IDX  = NIL[ADDR_SZ-1:0];
    localparam logic [ADDR_SZ:0]   TOP_ONE  = {{ADDR_SZ{1'b0}}, 1'b1};
    localparam logic [ADDR_SZ-1:0] USED_ONE = {{(ADDR_SZ-1){1'b0}}, 1'b1};
    localparam logic [15-ADDR_SZ:0] BASE_HI = BASE_ADDR[15:ADDR_SZ];

    function automatic logic [15:0] ext16(input logic [ADDR_SZ-1:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        v[ADDR_SZ-1:0] = idx;
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [ADDR_SZ:0]   top_r, top_s;
    logic [ADDR_SZ-1:0] head_r, head_s;
    logic [ADDR_SZ-1:0] used_r, used_s;
    logic [ADDR_SZ-1:0] pend_idx_r, pend_idx_s;
    logic [DATA_SZ-1:0] pend_data_r, pend_data_s;
    logic               valid_r, valid_s;
    logic [15:0]        addr_r, addr_s;
    logic               err_r, err_s;
    logic               rd_sel_r, rd_sel_s;
    logic               ready_r;
    logic               full_r;
    logic [DATA_SZ-1:0] hold_r;

    logic               ram_we_s;
    logic               ram_re_s;
    logic [ADDR_SZ-1:0] ram_addr_s;
    logic [DATA_SZ-1:0] ram_wdata_s;
    logic [DATA_SZ-1:0] ram_rdata_s;

    logic [ADDR_SZ-1:0] idx_s;
    logic               win_ok_s;
    logic               live_s;
    logic               tgt_ok_s;
    logic [DATA_SZ-1:0] link_s;

    assign idx_s    = bus.i_addr[ADDR_SZ-1:0];
    assign win_ok_s = (bus.i_addr[15:ADDR_SZ] == BASE_HI) && (idx_s != NIL_IDX);
    assign tgt_ok_s = win_ok_s && live_s;

`ifdef FREE_CHECK_EN
    localparam int CELLS = 2**ADDR_SZ;
    logic [CELLS-1:0] inuse_r, inuse_s;
    assign live_s = inuse_r[idx_s];
`else
    assign live_s = 1'b1;
`endif

    // Free-list link written into a freed cell: the current head, zero-extended.
    always_comb begin
        link_s = {DATA_SZ{1'b0}};
        link_s[ADDR_SZ-1:0] = head_r;
    end

    // Next-state, allocator bookkeeping and RAM port arbitration.
    always_comb begin
        state_s     = state_r;
        top_s       = top_r;
        head_s      = head_r;
        used_s      = used_r;
        pend_idx_s  = pend_idx_r;
        pend_data_s = pend_data_r;
        valid_s     = 1'b0;
        addr_s      = addr_r;
        err_s       = 1'b0;
        rd_sel_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = idx_s;
        ram_wdata_s = bus.i_data;
`ifdef FREE_CHECK_EN
        inuse_s     = inuse_r;
`endif
        case (state_r)
            ST_POP: begin
                // Old head's link arrived on rdata; the cell itself gets the latched initial value.
                ram_we_s    = 1'b1;
                ram_addr_s  = pend_idx_r;
                ram_wdata_s = pend_data_r;
                head_s      = ram_rdata_s[ADDR_SZ-1:0];
                used_s      = used_r + USED_ONE;
                valid_s     = 1'b1;
                addr_s      = cell_addr(BASE_ADDR, ext16(pend_idx_r));
                state_s     = ST_IDLE;
`ifdef FREE_CHECK_EN
                inuse_s[pend_idx_r] = 1'b1;
`endif
            end
            ST_IDLE: begin
                if (bus.i_alloc && bus.i_free && tgt_ok_s) begin
                    // Bypass: hand the freed cell straight back, list and count untouched.
                    ram_we_s = 1'b1;
                    valid_s  = 1'b1;
                    addr_s   = cell_addr(BASE_ADDR, ext16(idx_s));
                end else begin
                    if (bus.i_free) begin
                        if (tgt_ok_s) begin
                            ram_we_s    = 1'b1;
                            ram_wdata_s = link_s;
                            head_s      = idx_s;
                            used_s      = used_r - USED_ONE;
`ifdef FREE_CHECK_EN
                            inuse_s[idx_s] = 1'b0;
`endif
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        head_s = head_r;
                    end
                    if (bus.i_alloc) begin
                        if (head_r != NIL_IDX) begin
                            ram_re_s    = 1'b1;
                            ram_addr_s  = head_r;
                            pend_idx_s  = head_r;
                            pend_data_s = bus.i_data;
                            state_s     = ST_POP;
                        end else if (!top_r[ADDR_SZ]) begin
                            ram_we_s   = 1'b1;
                            ram_addr_s = top_r[ADDR_SZ-1:0];
                            top_s      = top_r + TOP_ONE;
                            used_s     = used_r + USED_ONE;
                            valid_s    = 1'b1;
                            addr_s     = cell_addr(BASE_ADDR, ext16(top_r[ADDR_SZ-1:0]));
`ifdef FREE_CHECK_EN
                            inuse_s[top_r[ADDR_SZ-1:0]] = 1'b1;
`endif
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                // Word access only when the port is not claimed by alloc/free.
                if (bus.i_rd || bus.i_wr) begin
                    if (bus.i_alloc || bus.i_free || !tgt_ok_s) begin
                        err_s = 1'b1;
                    end else if (bus.i_wr) begin
                        ram_we_s    = 1'b1;
                        ram_addr_s  = idx_s;
                        ram_wdata_s = bus.i_data;
                        err_s       = bus.i_rd;
                    end else begin
                        ram_re_s   = 1'b1;
                        ram_addr_s = idx_s;
                        rd_sel_s   = 1'b1;
                    end
                end else begin
                    rd_sel_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Allocator state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            top_r       <= TOP_ONE;
            head_r      <= NIL_IDX;
            used_r      <= {ADDR_SZ{1'b0}};
            pend_idx_r  <= NIL_IDX;
            pend_data_r <= {DATA_SZ{1'b0}};
            valid_r     <= 1'b0;
            addr_r      <= UNDEF;
            err_r       <= 1'b0;
            rd_sel_r    <= 1'b0;
            ready_r     <= 1'b1;
            full_r      <= 1'b0;
            hold_r      <= {DATA_SZ{1'b0}};
        end else begin
            top_r       <= top_s;
            head_r      <= head_s;
            used_r      <= used_s;
            pend_idx_r  <= pend_idx_s;
            pend_data_r <= pend_data_s;
            valid_r     <= valid_s;
            addr_r      <= addr_s;
            err_r       <= err_s;
            rd_sel_r    <= rd_sel_s;
            ready_r     <= (state_s == ST_IDLE);
            full_r      <= (head_s == NIL_IDX) && top_s[ADDR_SZ];
            hold_r      <= rd_sel_r ? ram_rdata_s : hold_r;
        end
    end

`ifdef FREE_CHECK_EN
    // In-use bitmap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inuse_r <= {CELLS{1'b0}};
        end else begin
            inuse_r <= inuse_s;
        end
    end
`endif

    cell_ram #(
        .ADDR_SZ(ADDR_SZ),
        .DATA_SZ(DATA_SZ)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we_s),
        .re   (ram_re_s),
        .addr (ram_addr_s),
        .wdata(ram_wdata_s),
        .rdata(ram_rdata_s)
    );

    // The read register feeds o_data directly in the cycle after a read; afterwards the captured copy holds.
    assign bus.o_data  = rd_sel_r ? ram_rdata_s : hold_r;
    assign bus.o_addr  = addr_r;
    assign bus.o_valid = valid_r;
    assign bus.o_ready = ready_r;
    assign bus.o_full  = full_r;
    assign bus.o_used  = used_r;
    assign bus.o_err   = err_r;

endmodule

// File: tb/tb_cell_pool.sv
// Directed table-driven bench for cell_pool (ADDR_SZ=4, DATA_SZ=16, window 16'h5000).
module tb_cell_pool;

    localparam logic [3:0] OP_N = 4'b0000;
    localparam logic [3:0] OP_A = 4'b1000;
    localparam logic [3:0] OP_F = 4'b0100;
    localparam logic [3:0] OP_R = 4'b0010;
    localparam logic [3:0] OP_W = 4'b0001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cell_pool_if #(.ADDR_SZ(4), .DATA_SZ(16)) bus ();

    cell_pool #(
        .ADDR_SZ(4),
        .DATA_SZ(16),
        .BASE_ADDR(16'h5000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic        e_valid;
        logic [15:0] e_addr;
        logic        e_err;
        logic        e_ready;
        logic [3:0]  e_used;
        logic        e_full;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data);
        bus.i_alloc = op[3];
        bus.i_free  = op[2];
        bus.i_rd    = op[1];
        bus.i_wr    = op[0];
        bus.i_addr  = addr;
        bus.i_data  = data;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] ea, input logic ee,
                              input logic er, input logic [3:0] eu, input logic ef, input logic [15:0] ed);
        check({tag, ".valid"}, {15'd0, bus.o_valid}, {15'd0, ev});
        check({tag, ".addr"},  bus.o_addr, ea);
        check({tag, ".err"},   {15'd0, bus.o_err}, {15'd0, ee});
        check({tag, ".ready"}, {15'd0, bus.o_ready}, {15'd0, er});
        check({tag, ".used"},  {12'd0, bus.o_used}, {12'd0, eu});
        check({tag, ".full"},  {15'd0, bus.o_full}, {15'd0, ef});
        check({tag, ".data"},  bus.o_data, ed);
    endtask

    // One cycle: present inputs, let the edge pass, sample 1 time unit later.
    task automatic step(input string tag, input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input logic ev, input logic [15:0] ea, input logic ee, input logic er,
                        input logic [3:0] eu, input logic ef, input logic [15:0] ed);
        drive(op, addr, data);
        @(posedge clk);
        #1;
        check_outs(tag, ev, ea, ee, er, eu, ef, ed);
    endtask

    task automatic add(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data,
                       input logic ev, input logic [15:0] ea, input logic ee, input logic er,
                       input logic [3:0] eu, input logic ef, input logic [15:0] ed);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data;
        v.e_valid = ev; v.e_addr = ea; v.e_err = ee; v.e_ready = er;
        v.e_used = eu; v.e_full = ef; v.e_data = ed;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(OP_N, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000);
        rst = 1'b0;

        // Fresh allocs, LIFO reuse, free ignored while busy, bypass.
        add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5001, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5002, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5003, 1'b0, 1'b1, 4'd3, 1'b0, 16'h0000);
        add(OP_F, 16'h5001, 16'h0000, 1'b0, 16'h5003, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000);
        add(OP_F, 16'h5003, 16'h0000, 1'b0, 16'h5003, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b0, 16'h5003, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0000);
        add(OP_F, 16'h5002, 16'h0000, 1'b1, 16'h5003, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b0, 16'h5003, 1'b0, 1'b0, 4'd2, 1'b0, 16'h0000);
        add(OP_N, 16'h0000, 16'h0000, 1'b1, 16'h5001, 1'b0, 1'b1, 4'd3, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5004, 1'b0, 1'b1, 4'd4, 1'b0, 16'h0000);
        add(OP_A | OP_F, 16'h5002, 16'h0000, 1'b1, 16'h5002, 1'b0, 1'b1, 4'd4, 1'b0, 16'h0000);
        add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5005, 1'b0, 1'b1, 4'd5, 1'b0, 16'h0000);
        // Word access and error cases.
        add(OP_A, 16'h0000, 16'hABCD, 1'b1, 16'h5006, 1'b0, 1'b1, 4'd6, 1'b0, 16'h0000);
        add(OP_R, 16'h5006, 16'h0000, 1'b0, 16'h5006, 1'b0, 1'b1, 4'd6, 1'b0, 16'hABCD);
        add(OP_W, 16'h5006, 16'h1234, 1'b0, 16'h5006, 1'b0, 1'b1, 4'd6, 1'b0, 16'hABCD);
        add(OP_R, 16'h5006, 16'h0000, 1'b0, 16'h5006, 1'b0, 1'b1, 4'd6, 1'b0, 16'h1234);
        add(OP_R, 16'h5000, 16'h0000, 1'b0, 16'h5006, 1'b1, 1'b1, 4'd6, 1'b0, 16'h1234);
        add(OP_F, 16'h6001, 16'h0000, 1'b0, 16'h5006, 1'b1, 1'b1, 4'd6, 1'b0, 16'h1234);
        add(OP_R | OP_W, 16'h5006, 16'h5555, 1'b0, 16'h5006, 1'b1, 1'b1, 4'd6, 1'b0, 16'h1234);
        add(OP_R, 16'h5006, 16'h0000, 1'b0, 16'h5006, 1'b0, 1'b1, 4'd6, 1'b0, 16'h5555);
        add(OP_A | OP_R, 16'h5001, 16'h0000, 1'b1, 16'h5007, 1'b1, 1'b1, 4'd7, 1'b0, 16'h5555);
        add(OP_N, 16'h0000, 16'h0000, 1'b0, 16'h5007, 1'b0, 1'b1, 4'd7, 1'b0, 16'h5555);
        // Fill to capacity.
        for (int i = 0; i < 8; i++) begin
            add(OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5008 + 16'(i), 1'b0, 1'b1, 4'(8 + i), (i == 7), 16'h5555);
        end
        add(OP_A, 16'h0000, 16'h0000, 1'b0, 16'h500F, 1'b1, 1'b1, 4'd15, 1'b1, 16'h5555);
        add(OP_F, 16'h6001, 16'h0000, 1'b0, 16'h500F, 1'b1, 1'b1, 4'd15, 1'b1, 16'h5555);
        add(OP_F, 16'h500F, 16'h0000, 1'b0, 16'h500F, 1'b0, 1'b1, 4'd14, 1'b0, 16'h5555);
        add(OP_A | OP_F, 16'h6001, 16'h0000, 1'b0, 16'h500F, 1'b1, 1'b0, 4'd14, 1'b0, 16'h5555);
        add(OP_N, 16'h0000, 16'h0000, 1'b1, 16'h500F, 1'b0, 1'b1, 4'd15, 1'b1, 16'h5555);
        add(OP_F, 16'h5003, 16'h0000, 1'b0, 16'h500F, 1'b0, 1'b1, 4'd14, 1'b0, 16'h5555);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data,
                 tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_err, tbl[i].e_ready,
                 tbl[i].e_used, tbl[i].e_full, tbl[i].e_data);
        end

        // Reset while a free-list pop is in flight.
        step("pop_start", OP_A, 16'h0000, 16'h0000, 1'b0, 16'h500F, 1'b0, 1'b0, 4'd14, 1'b0, 16'h5555);
        rst = 1'b1;
        step("rst_in_pop", OP_N, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000);
        rst = 1'b0;
        step("post_rst_alloc", OP_A, 16'h0000, 16'h00C3, 1'b1, 16'h5001, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000);
        step("post_rst_rd", OP_R, 16'h5001, 16'h0000, 1'b0, 16'h5001, 1'b0, 1'b1, 4'd1, 1'b0, 16'h00C3);

`ifdef FREE_CHECK_EN
        step("fc_alloc", OP_A, 16'h0000, 16'h0000, 1'b1, 16'h5002, 1'b0, 1'b1, 4'd2, 1'b0, 16'h00C3);
        step("fc_free1", OP_F, 16'h5002, 16'h0000, 1'b0, 16'h5002, 1'b0, 1'b1, 4'd1, 1'b0, 16'h00C3);
        step("fc_free2", OP_F, 16'h5002, 16'h0000, 1'b0, 16'h5002, 1'b1, 1'b1, 4'd1, 1'b0, 16'h00C3);
        step("fc_rd_freed", OP_R, 16'h5002, 16'h0000, 1'b0, 16'h5002, 1'b1, 1'b1, 4'd1, 1'b0, 16'h00C3);
        step("fc_wr_never", OP_W, 16'h5009, 16'h7777, 1'b0, 16'h5002, 1'b1, 1'b1, 4'd1, 1'b0, 16'h00C3);
        step("fc_rd_live", OP_R, 16'h5001, 16'h0000, 1'b0, 16'h5002, 1'b0, 1'b1, 4'd1, 1'b0, 16'h00C3);
`endif

        drive(OP_N, 16'h0000, 16'h0000);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
